decode_stage: RTL and testbench

- Registered RV32I decode stage with a valid/ready handshake and an output queue of configurable depth; sits between fetch and execute.
- Generalises the combinational instruction-to-control decoder:
  - full RV32I opcode coverage (LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD/STORE all widths, all six branches);
  - illegal-instruction detection;
  - flush support;
  - backpressure buffering.

---
 rtl/decode_stage_pkg.sv | 83 ++++++++
 rtl/decode_stage_core.sv | 165 ++++++++++++++++
 rtl/decode_stage.sv | 105 ++++++++++
 tb/tb_decode_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// ============================================================================
// decode_stage_pkg : shared RV32I decode types, control word and opcodes
// Revision: 1.0
// ============================================================================
`default_nettype none

package decode_stage_pkg;

   typedef logic [31:0] instruction_type;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_LUI    = 5'd10,
      ALU_MUL    = 5'd11,
      ALU_MULH   = 5'd12,
      ALU_MULHSU = 5'd13,
      ALU_MULHU  = 5'd14,
      ALU_DIV    = 5'd15,
      ALU_DIVU   = 5'd16,
      ALU_REM    = 5'd17,
      ALU_REMU   = 5'd18
   } alu_op_type;

   typedef enum logic [2:0] {
      BRANCH_BEQ  = 3'd0,
      BRANCH_BNE  = 3'd1,
      BRANCH_BLT  = 3'd2,
      BRANCH_BGE  = 3'd3,
      BRANCH_BLTU = 3'd4,
      BRANCH_BGEU = 3'd5
   } branch_type;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_type;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_type;

   typedef struct packed {
      logic         RegWrite;
      logic         ALUSrc;
      logic         ALUSrcA;
      alu_op_type   ALUOp;
      logic         is_branch;
      branch_type   BranchType;
      logic         is_jump;
      logic         MemRead;
      logic         MemWrite;
      mem_size_type MemSize;
      logic         MemSignExt;
      wb_sel_type   WBSel;
      logic         is_muldiv;
      logic         illegal;
   } control_type;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

`default_nettype wire

// File: rtl/decode_stage_core.sv
// ============================================================================
// decode_core : combinational RV32I instruction -> control word decoder
// Optional RV32M_EN enables M-extension decode. Revision: 1.0
// ============================================================================
`default_nettype none

module decode_core
   import decode_stage_pkg::*;
(
   input  instruction_type instruction_i,
   output control_type     control_o,
   output logic            illegal_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        unused_fields;
   control_type ctrl;
   logic        ok;

   assign opcode        = instruction_i[6:0];
   assign funct3        = instruction_i[14:12];
   assign funct7        = instruction_i[31:25];
   assign unused_fields = ^{instruction_i[24:15], instruction_i[11:7]};

   always_comb begin
      ctrl = '0;
      ok   = 1'b1;
      case (opcode)
         OPC_LUI: begin
            ctrl.RegWrite = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            ctrl.ALUOp    = ALU_LUI;
         end
         OPC_AUIPC: begin
            ctrl.RegWrite = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            ctrl.ALUSrcA  = 1'b1;
         end
         OPC_JAL: begin
            ctrl.RegWrite = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            ctrl.ALUSrcA  = 1'b1;
            ctrl.is_jump  = 1'b1;
            ctrl.WBSel    = WB_PC4;
         end
         OPC_JALR: begin
            ctrl.RegWrite = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            ctrl.is_jump  = 1'b1;
            ctrl.WBSel    = WB_PC4;
            ok            = (funct3 == 3'b000);
         end
         OPC_BRANCH: begin
            ctrl.is_branch = 1'b1;
            case (funct3)
               3'b000:  ctrl.BranchType = BRANCH_BEQ;
               3'b001:  ctrl.BranchType = BRANCH_BNE;
               3'b100:  ctrl.BranchType = BRANCH_BLT;
               3'b101:  ctrl.BranchType = BRANCH_BGE;
               3'b110:  ctrl.BranchType = BRANCH_BLTU;
               3'b111:  ctrl.BranchType = BRANCH_BGEU;
               default: ok = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            ctrl.RegWrite   = 1'b1;
            ctrl.ALUSrc     = 1'b1;
            ctrl.MemRead    = 1'b1;
            ctrl.WBSel      = WB_MEM;
            ctrl.MemSignExt = ~funct3[2];
            case (funct3)
               3'b000, 3'b100: ctrl.MemSize = MEM_BYTE;
               3'b001, 3'b101: ctrl.MemSize = MEM_HALF;
               3'b010:         ctrl.MemSize = MEM_WORD;
               default:        ok = 1'b0;
            endcase
         end
         OPC_STORE: begin
            ctrl.ALUSrc   = 1'b1;
            ctrl.MemWrite = 1'b1;
            case (funct3)
               3'b000:  ctrl.MemSize = MEM_BYTE;
               3'b001:  ctrl.MemSize = MEM_HALF;
               3'b010:  ctrl.MemSize = MEM_WORD;
               default: ok = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            ctrl.RegWrite = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            case (funct3)
               3'b000: ctrl.ALUOp = ALU_ADD;
               3'b010: ctrl.ALUOp = ALU_SLT;
               3'b011: ctrl.ALUOp = ALU_SLTU;
               3'b100: ctrl.ALUOp = ALU_XOR;
               3'b110: ctrl.ALUOp = ALU_OR;
               3'b111: ctrl.ALUOp = ALU_AND;
               3'b001: begin
                  ctrl.ALUOp = ALU_SLL;
                  ok         = (funct7 == 7'b0000000);
               end
               default: begin
                  ctrl.ALUOp = (funct7[5]) ? ALU_SRA : ALU_SRL;
                  ok         = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               end
            endcase
         end
         OPC_OP: begin
            ctrl.RegWrite = 1'b1;
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  ctrl.ALUOp = ALU_ADD;
                  3'b001:  ctrl.ALUOp = ALU_SLL;
                  3'b010:  ctrl.ALUOp = ALU_SLT;
                  3'b011:  ctrl.ALUOp = ALU_SLTU;
                  3'b100:  ctrl.ALUOp = ALU_XOR;
                  3'b101:  ctrl.ALUOp = ALU_SRL;
                  3'b110:  ctrl.ALUOp = ALU_OR;
                  default: ctrl.ALUOp = ALU_AND;
               endcase
            end else if (funct7 == 7'b0100000) begin
               case (funct3)
                  3'b000:  ctrl.ALUOp = ALU_SUB;
                  3'b101:  ctrl.ALUOp = ALU_SRA;
                  default: ok = 1'b0;
               endcase
`ifdef RV32M_EN
            end else if (funct7 == 7'b0000001) begin
               ctrl.is_muldiv = 1'b1;
               case (funct3)
                  3'b000:  ctrl.ALUOp = ALU_MUL;
                  3'b001:  ctrl.ALUOp = ALU_MULH;
                  3'b010:  ctrl.ALUOp = ALU_MULHSU;
                  3'b011:  ctrl.ALUOp = ALU_MULHU;
                  3'b100:  ctrl.ALUOp = ALU_DIV;
                  3'b101:  ctrl.ALUOp = ALU_DIVU;
                  3'b110:  ctrl.ALUOp = ALU_REM;
                  default: ctrl.ALUOp = ALU_REMU;
               endcase
`endif
            end else begin
               ok = 1'b0;
            end
         end
         default: ok = 1'b0;
      endcase
   end

   // Unmatched encodings collapse to an all-zero control word flagged illegal.
   always_comb begin
      control_o = '0;
      if (ok) begin
         control_o = ctrl;
      end else begin
         control_o.illegal = 1'b1;
      end
   end

   assign illegal_o = ~ok;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : registered RV32I decode with valid/ready queue and flush
// Optional RV32M_EN (in decode_core) enables M-extension decode. Revision: 1.0
// ============================================================================
`default_nettype none

module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  instruction_type in_instruction,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output control_type     out_control,
   output instruction_type out_instruction,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   localparam int         AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   typedef struct packed {
      control_type     control;
      instruction_type instr;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   control_type     dec_control;
   logic            dec_illegal;
   logic            push, pop;
   entry_t          head;

   decode_core u_core (
      .instruction_i (in_instruction),
      .control_o     (dec_control),
      .illegal_o     (dec_illegal)
   );

   assign in_ready  = (count_q < FULL);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{control: dec_control, instr: in_instruction,
                              pc: in_pc, illegal: dec_illegal};
      end
   end

   // Storage is not reset, so the empty-queue view is forced to zero.
   assign head            = mem_q[rd_ptr_q];
   assign out_control     = out_valid ? head.control : '0;
   assign out_instruction = out_valid ? head.instr   : '0;
   assign out_pc          = out_valid ? head.pc      : '0;
   assign out_illegal     = out_valid & head.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage : directed self-checking bench for decode_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;
   import decode_stage_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   instruction_type in_instruction;
   logic [31:0]     in_pc;
   logic            out_valid;
   logic            out_ready;
   control_type     out_control;
   instruction_type out_instruction;
   logic [31:0]     out_pc;
   logic            out_illegal;

   int checks   = 0;
   int failures = 0;

   control_type e_addi, e_bge, e_add, e_ill, e_lw, e_jalr, e_mul;

   decode_stage #(.XLEN(32), .DEPTH(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instruction  (in_instruction),
      .in_pc           (in_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_control     (out_control),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .out_illegal     (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      in_valid       = v;
      in_instruction = ins;
      in_pc          = pc;
      out_ready      = rdy;
      flush          = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      e_addi = '0; e_addi.RegWrite = 1'b1; e_addi.ALUSrc = 1'b1; e_addi.ALUOp = ALU_ADD;
      e_bge  = '0; e_bge.is_branch = 1'b1; e_bge.BranchType = BRANCH_BGE;
      e_add  = '0; e_add.RegWrite = 1'b1; e_add.ALUOp = ALU_ADD;
      e_ill  = '0; e_ill.illegal = 1'b1;
      e_lw   = '0; e_lw.RegWrite = 1'b1; e_lw.ALUSrc = 1'b1; e_lw.MemRead = 1'b1;
      e_lw.MemSize = MEM_WORD; e_lw.MemSignExt = 1'b1; e_lw.WBSel = WB_MEM;
      e_jalr = '0; e_jalr.RegWrite = 1'b1; e_jalr.ALUSrc = 1'b1; e_jalr.is_jump = 1'b1;
      e_jalr.WBSel = WB_PC4;
      e_mul  = '0; e_mul.RegWrite = 1'b1; e_mul.ALUOp = ALU_MUL; e_mul.is_muldiv = 1'b1;

      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_control", 64'(out_control), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      chk("rst_instr", 64'(out_instruction), 64'd0);
      chk("rst_illegal", 64'(out_illegal), 64'd0);
      #1 rst = 1'b0;

      // addi x1,x0,5: one-cycle latency
      tick();
      drive(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
      tick();
      chk("addi_valid", 64'(out_valid), 64'd1);
      chk("addi_control", 64'(out_control), 64'(e_addi));
      chk("addi_pc", 64'(out_pc), 64'h100);
      chk("addi_instr", 64'(out_instruction), 64'h00500093);
      chk("addi_illegal", 64'(out_illegal), 64'd0);

      // bge pushed while addi pops
      drive(1'b1, 32'h0020D063, 32'h104, 1'b1, 1'b0);
      tick();
      chk("bge_valid", 64'(out_valid), 64'd1);
      chk("bge_control", 64'(out_control), 64'(e_bge));
      chk("bge_pc", 64'(out_pc), 64'h104);

      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("drain_valid", 64'(out_valid), 64'd0);
      tick();
      chk("empty_pop_valid", 64'(out_valid), 64'd0);
      chk("empty_pop_ready", 64'(in_ready), 64'd1);

      // backpressure: fill to DEPTH, offer a third while full
      drive(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
      tick();
      chk("bp1_ready", 64'(in_ready), 64'd1);
      drive(1'b1, 32'h00208133, 32'h204, 1'b0, 1'b0);
      tick();
      chk("bp2_ready", 64'(in_ready), 64'd0);
      chk("bp2_head_pc", 64'(out_pc), 64'h200);
      drive(1'b1, 32'hDEADBEEF, 32'h208, 1'b0, 1'b0);
      tick();
      chk("bp3_head_pc", 64'(out_pc), 64'h200);
      chk("bp3_head_instr", 64'(out_instruction), 64'h00100113);
      chk("bp3_ready", 64'(in_ready), 64'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("bp4_ready", 64'(in_ready), 64'd1);
      chk("bp4_head_pc", 64'(out_pc), 64'h204);
      chk("bp4_control", 64'(out_control), 64'(e_add));
      tick();
      chk("bp5_valid", 64'(out_valid), 64'd0);

      // mul x3,x1,x2
      drive(1'b1, 32'h022081B3, 32'h300, 1'b0, 1'b0);
      tick();
`ifdef RV32M_EN
      chk("mul_control", 64'(out_control), 64'(e_mul));
      chk("mul_illegal", 64'(out_illegal), 64'd0);
`else
      chk("mul_control", 64'(out_control), 64'(e_ill));
      chk("mul_illegal", 64'(out_illegal), 64'd1);
`endif

      // all-ones word replaces mul at the head
      drive(1'b1, 32'hFFFFFFFF, 32'h304, 1'b1, 1'b0);
      tick();
      chk("ones_pc", 64'(out_pc), 64'h304);
      chk("ones_illegal", 64'(out_illegal), 64'd1);
      chk("ones_regwrite", 64'(out_control.RegWrite), 64'd0);
      chk("ones_memwrite", 64'(out_control.MemWrite), 64'd0);
      chk("ones_control", 64'(out_control), 64'(e_ill));

      // lw x5,0(x1)
      drive(1'b1, 32'h0000A283, 32'h308, 1'b1, 1'b0);
      tick();
      chk("lw_pc", 64'(out_pc), 64'h308);
      chk("lw_control", 64'(out_control), 64'(e_lw));

      // flush with one entry and an acceptable input
      drive(1'b1, 32'h0050A223, 32'h30C, 1'b0, 1'b1);
      tick();
      chk("flush1_valid", 64'(out_valid), 64'd0);
      chk("flush1_ready", 64'(in_ready), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("flush1_after", 64'(out_valid), 64'd0);

      // flush with the queue holding two entries
      drive(1'b1, 32'h00100113, 32'h400, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h00208133, 32'h404, 1'b0, 1'b0);
      tick();
      chk("flush2_full", 64'(in_ready), 64'd0);
      drive(1'b1, 32'h0050A223, 32'h408, 1'b0, 1'b1);
      tick();
      chk("flush2_valid", 64'(out_valid), 64'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("flush2_after", 64'(out_valid), 64'd0);

      // jalr, then slli with a bad funct7
      drive(1'b1, 32'h000080E7, 32'h500, 1'b0, 1'b0);
      tick();
      chk("jalr_control", 64'(out_control), 64'(e_jalr));
      drive(1'b1, 32'h02009093, 32'h504, 1'b1, 1'b0);
      tick();
      chk("slli_bad_control", 64'(out_control), 64'(e_ill));
      chk("slli_bad_illegal", 64'(out_illegal), 64'd1);

      // asynchronous reset between edges
      drive(1'b1, 32'h00500093, 32'h600, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("pre_areset_valid", 64'(out_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("areset_valid", 64'(out_valid), 64'd0);
      chk("areset_ready", 64'(in_ready), 64'd1);
      #1 rst = 1'b0;
      tick();
      chk("post_areset_valid", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
